// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Start/busy/done handshake; quotient goes to LO and remainder to HI, both held until the next completion.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic             busy_r, busy_s, done_r, done_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] rem_r, quo_r, dsr_r, dvd_r;
    logic             neg_q_r, neg_r_r, dbz_r;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             dbz_out_r;
    logic             accept_s, last_s;
    logic [WIDTH:0]   shifted_s, trial_s;
    logic [WIDTH-1:0] rem_step_s, quo_step_s;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + WIDTH'(1)) : v;
    endfunction

    // Two's-complement magnitude; |most-negative| wraps to itself, which is correct as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return cond_neg(v, sgn & v[WIDTH-1]);
    endfunction

    assign accept_s = start & ~cancel & ((state_r == S_IDLE) | (state_r == S_DONE));
    assign last_s   = (state_r == S_BUSY) & ~cancel & (cnt_r == CW'(0));

    // State and handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state selection
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start && !cancel) state_s = S_BUSY;
                else                  state_s = S_IDLE;
            end
            S_BUSY: begin
                if (cancel)                  state_s = S_IDLE;
                else if (cnt_r == CW'(0))    state_s = S_DONE;
                else                         state_s = S_BUSY;
            end
            S_DONE: begin
                if (start && !cancel) state_s = S_BUSY;
                else                  state_s = S_IDLE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state so they can be registered
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        if (state_s == S_BUSY) busy_s = 1'b1;
        else                   busy_s = 1'b0;
        if (state_s == S_DONE) done_s = 1'b1;
        else                   done_s = 1'b0;
    end

    // One restoring step: shift in the next dividend bit, keep the trial difference if non-negative
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dsr_r};
        if (!trial_s[WIDTH]) begin
            rem_step_s = trial_s[WIDTH-1:0];
            quo_step_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_step_s = shifted_s[WIDTH-1:0];
            quo_step_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Operand latch, iteration, and result registers (results change only on entry to DONE)
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= CW'(0);
            rem_r       <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            dsr_r       <= {WIDTH{1'b0}};
            dvd_r       <= {WIDTH{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            dbz_r       <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_out_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                cnt_r   <= CW'(WIDTH - 1);
                rem_r   <= {WIDTH{1'b0}};
                quo_r   <= mag(dividend, is_signed);
                dsr_r   <= mag(divisor, is_signed);
                dvd_r   <= dividend;
                neg_q_r <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                neg_r_r <= is_signed & dividend[WIDTH-1];
                dbz_r   <= (divisor == {WIDTH{1'b0}});
            end else if ((state_r == S_BUSY) && !cancel) begin
                rem_r <= rem_step_s;
                quo_r <= quo_step_s;
                if (cnt_r != CW'(0)) cnt_r <= cnt_r - CW'(1);
                else                 cnt_r <= cnt_r;
            end
            if (last_s) begin
                if (dbz_r) begin
                    quotient_r  <= {WIDTH{1'b1}};
                    remainder_r <= dvd_r;
                    dbz_out_r   <= 1'b1;
                end else begin
                    quotient_r  <= cond_neg(quo_step_s, neg_q_r);
                    remainder_r <= cond_neg(rem_step_s, neg_r_r);
                    dbz_out_r   <= 1'b0;
                end
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_out_r;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a negedge monitor pops on done.
module tb_div_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst, start, cancel, is_signed;
    logic [WIDTH-1:0] dividend, divisor;
    logic             busy, done, div_by_zero;
    logic [WIDTH-1:0] quotient, remainder;

    typedef struct {
        string            nm;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .cancel(cancel), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: on every done pulse, compare against the oldest expectation
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            check("busy_done_exclusive", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.nm, "_quotient"}, quotient, e.q);
                check({e.nm, "_remainder"}, remainder, e.r);
                check({e.nm, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
                check({e.nm, "_latency"}, cyc, e.cyc);
            end
        end
    end

    task automatic start_raw(input logic sg, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        is_signed = sg; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic issue(input string nm, input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edbz);
        exp_t e;
        start_raw(sg, a, b);
        e.nm = nm; e.q = eq; e.r = er; e.dbz = edbz; e.cyc = cyc + WIDTH;
        sb.push_back(e);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'd1, 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; start = 1'b0; cancel = 1'b0; is_signed = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;

        issue("u_100_7",   1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);                      drain();
        issue("s_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0); drain();
        issue("s_7_m2",    1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);         drain();
        issue("s_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0); drain();
        issue("u_max_1",   1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);         drain();
        issue("u_dbz",     1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);                 drain();
        issue("s_dbz",     1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1); drain();
        issue("u_big",     1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0); drain();
        issue("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0); drain();

        // Cancel mid-flight: no done, previous results held
        start_raw(1'b0, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy_low", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("cancel_q_held", quotient, 32'd14);
        check("cancel_r_held", remainder, 32'hFFFF_FFFE);

        // start together with cancel in IDLE is dropped
        @(negedge clk);
        is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cancel_wins_idle", {31'd0, busy}, 32'd0);

        // start during BUSY is ignored
        issue("u_50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        start_raw(1'b0, 32'd9, 32'd3);
        drain();
        repeat (40) @(negedge clk);
        check("ignored_start_q", quotient, 32'd10);

        // Back-to-back: start held in the DONE cycle
        issue("b2b_a", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        check("b2b_done_seen", {31'd0, done}, 32'd1);
        is_signed = 1'b1; dividend = 32'hFFFF_FFF7; divisor = 32'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        e.nm = "b2b_b"; e.q = 32'hFFFF_FFFE; e.r = 32'hFFFF_FFFF; e.dbz = 1'b0; e.cyc = cyc + WIDTH;
        sb.push_back(e);
        drain();

        // Reset mid-operation clears outputs and suppresses done
        start_raw(1'b0, 32'd100, 32'd7);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_quotient", quotient, 32'd0);
        check("mrst_remainder", remainder, 32'd0);
        check("mrst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue("after_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        drain();

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
